// File: rtl/alu_seq.sv
// Multi-cycle ALU: add/sub, shift-add multiply, bit-serial shifts and bitwise logic,
// launched by a start/busy/done handshake with flags registered alongside the result.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               overflow,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(RW);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  typedef enum logic [2:0] {
    OP_NOP = 3'b000, OP_ADD = 3'b001, OP_MUL = 3'b010, OP_SHL = 3'b011,
    OP_SHR = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_XOR = 3'b111
  } op_t;

  state_t           state, state_next;
  op_t              op_r;
  logic [WIDTH-1:0] a_r, b_r, mplier;
  logic             cin_r, ovf_r;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    acc, sreg;

  logic             accept, shamt_clamp;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [RW-1:0]    res_next;
  logic             carry_next, ovf_next;

  assign accept      = (state == IDLE) && start;
  assign shamt_clamp = 32'(b) >= 32'(RW);
  assign busy        = (state == RUN);
  assign done        = (state == FIN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == '0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Final result and flags, evaluated from the latched operands and the
  // iteration registers on the last RUN cycle.
  always_comb begin
    res_next   = '0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    b_eff      = cin_r ? ~b_r : b_r;
    sum        = {1'b0, a_r} + {1'b0, b_eff} + (WIDTH + 1)'(cin_r);
    case (op_r)
      OP_ADD: begin
        carry_next = sum[WIDTH];
        ovf_next   = (a_r[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
        res_next   = cin_r ? RW'(sum[WIDTH-1:0]) : RW'(sum);
      end
      OP_MUL: begin
        res_next = acc;
        ovf_next = |acc[RW-1:WIDTH];
      end
      OP_SHL: begin
        res_next = sreg;
        ovf_next = ovf_r;
      end
      OP_SHR:  res_next = sreg;
      OP_AND:  res_next = RW'(a_r & b_r);
      OP_OR:   res_next = RW'(a_r | b_r);
      OP_XOR:  res_next = RW'(a_r ^ b_r);
      default: res_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r     <= OP_NOP;
      a_r      <= '0;
      b_r      <= '0;
      cin_r    <= 1'b0;
      mplier   <= '0;
      cnt      <= '0;
      acc      <= '0;
      sreg     <= '0;
      ovf_r    <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else if (accept) begin
      op_r   <= op_t'(op);
      a_r    <= a;
      b_r    <= b;
      cin_r  <= cin;
      mplier <= b;
      acc    <= '0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
      sreg   <= '0;
      case (op_t'(op))
        OP_MUL: begin
          cnt  <= CW'(WIDTH);
          sreg <= RW'(a);
        end
        OP_SHL, OP_SHR: begin
          // An out-of-range amount finishes immediately; a left shift then
          // reports overflow if any set bit was discarded.
          if (shamt_clamp) begin
            ovf_r <= |a;
          end else begin
            cnt  <= CW'(b);
            sreg <= RW'(a);
          end
        end
        default: ;
      endcase
    end else if (state == RUN) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        case (op_r)
          OP_MUL: begin
            if (mplier[0]) acc <= acc + sreg;
            sreg   <= sreg << 1;
            mplier <= mplier >> 1;
          end
          OP_SHL: begin
            ovf_r <= ovf_r | sreg[RW-1];
            sreg  <= sreg << 1;
          end
          OP_SHR:  sreg <= sreg >> 1;
          default: ;
        endcase
      end else begin
        result   <= res_next;
        carry    <= carry_next;
        overflow <= ovf_next;
        zero     <= (res_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq: expected results, flags and done
// timing come from an arithmetic reference model and are checked on each done pulse.
module tb_alu_seq;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic [RW-1:0] result;
  logic          carry, overflow, zero, busy, done;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint res;
    bit     c;
    bit     v;
    bit     z;
    int     cyc;
    string  name;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  longint held = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(logic [2:0] mop, int ma, int mb, bit mcin);
    exp_t   e;
    longint r, full;
    int     sa, sbv, sd, n;
    bit     c, v;
    r = 0; c = 0; v = 0; n = 0;
    sa  = (ma >= 2**(W-1)) ? ma - 2**W : ma;
    sbv = (mb >= 2**(W-1)) ? mb - 2**W : mb;
    case (mop)
      3'd1: begin
        if (!mcin) begin
          r  = ma + mb;
          c  = (r >= 2**W);
          sd = sa + sbv;
        end else begin
          r  = (ma - mb + 2**W) % 2**W;
          c  = (ma >= mb);
          sd = sa - sbv;
        end
        v = (sd > 2**(W-1) - 1) || (sd < -(2**(W-1)));
      end
      3'd2: begin
        r = ma * mb;
        v = (r >= 2**W);
        n = W;
      end
      3'd3: begin
        if (mb >= RW) begin
          r = 0;
          v = (ma != 0);
        end else begin
          full = longint'(ma) << mb;
          r    = full % (longint'(1) << RW);
          v    = (full >> RW) != 0;
          n    = mb;
        end
      end
      3'd4: begin
        if (mb < RW) begin
          r = ma >> mb;
          n = mb;
        end
      end
      3'd5: r = ma & mb;
      3'd6: r = ma | mb;
      3'd7: r = ma ^ mb;
      default: r = 0;
    endcase
    e.res  = r;
    e.c    = c;
    e.v    = v;
    e.z    = (r == 0);
    e.cyc  = n;
    e.name = $sformatf("op%0d_a%0d_b%0d_c%0d", mop, ma, mb, mcin);
    return e;
  endfunction

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((busy || done) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy || done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles, expected idle", busy, done, k);
    end
  endtask

  task automatic launch(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y, bit ci, bit push);
    exp_t e;
    wait_idle();
    op = o; a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e = model(o, int'(x), int'(y), ci);
      e.cyc = cyc + 1 + e.cyc;
      sb.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_result"},   result,   0);
    check({tag, "_carry"},    carry,    0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_zero"},     zero,     1);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
  endtask

  // Monitor: pops the scoreboard on every done pulse; outputs must hold while busy.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result 0x%0h with no operation pending", result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"},   result,   mon_e.res);
        check({mon_e.name, "_carry"},    carry,    mon_e.c);
        check({mon_e.name, "_overflow"}, overflow, mon_e.v);
        check({mon_e.name, "_zero"},     zero,     mon_e.z);
        check({mon_e.name, "_done_cyc"}, cyc,      mon_e.cyc);
        check({mon_e.name, "_busy_low"}, busy,     0);
      end
    end else if (busy) begin
      check("hold_result", result, held);
    end
    if (!busy) held = result;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed cases from the operation definitions and boundaries.
    launch(3'd1, 4'd9,  4'd8,  1'b0, 1'b1);
    launch(3'd1, 4'd3,  4'd5,  1'b1, 1'b1);
    launch(3'd1, 4'd5,  4'd5,  1'b1, 1'b1);
    launch(3'd2, 4'd15, 4'd15, 1'b0, 1'b1);
    launch(3'd2, 4'd0,  4'd9,  1'b0, 1'b1);
    launch(3'd3, 4'hB,  4'd3,  1'b0, 1'b1);
    launch(3'd3, 4'hB,  4'd9,  1'b0, 1'b1);
    launch(3'd3, 4'hF,  4'd7,  1'b0, 1'b1);
    launch(3'd4, 4'hB,  4'd2,  1'b0, 1'b1);
    launch(3'd4, 4'hB,  4'd8,  1'b0, 1'b1);
    launch(3'd5, 4'hC,  4'hA,  1'b0, 1'b1);
    launch(3'd6, 4'hC,  4'hA,  1'b0, 1'b1);
    launch(3'd7, 4'hC,  4'hA,  1'b0, 1'b1);
    launch(3'd0, 4'hF,  4'hF,  1'b1, 1'b1);

    // Start held high with fresh operands while busy must be ignored.
    launch(3'd2, 4'd13, 4'd11, 1'b0, 1'b1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) break;
      start = 1'b1;
      op    = 3'($urandom_range(1, 7));
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
    end
    start = 1'b0;

    // Reset two edges into a multiply aborts it without a done pulse.
    launch(3'd2, 4'd15, 4'd15, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    repeat (8) @(negedge clk);
    launch(3'd1, 4'd7, 4'd6, 1'b0, 1'b1);

    repeat (60) begin
      launch(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
